// File: rtl/uart_tx_io.sv
// UART transmitter on the CPU IO bus: snoops IO writes, buffers bytes in a FIFO
// and shifts them out 8N1, LSB first. Status/control live at BASE_ADDR+1.
module uart_tx_io #(
  parameter logic [8:0]  BASE_ADDR = 9'd42,
  parameter logic [15:0] DIV_RESET = 16'd434,
  parameter int          FIFO_AW   = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [8:0]  AddressIO,
  input  logic [31:0] DataOutput,
  input  logic        WriteIO,
  output logic [31:0] RdData,
  output logic        RdHit,
  output logic        TX
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

  txStateT              stateReg, stateNext;
  logic [15:0]          baudReg, baudNext;
  logic [2:0]           bitReg, bitNext;
  logic [15:0]          divP, divA;
  logic [7:0]           shreg;
  logic [7:0]           lastByte;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]        countReg;
  logic                 wrQ;
  logic                 ovf;
  logic [1:0]           hit;
  logic                 strobe, wrData, wrCtrl;
  logic                 full, empty, busy;
  logic                 pushEn, popEn, shiftEn, bitEnd;
  logic [31:0]          statusWord;
  logic                 unusedBits;

  // hit[0] = data register, hit[1] = status/control register
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gDecode
      assign hit[gi] = (AddressIO == BASE_ADDR + 9'(gi));
    end
  endgenerate

  assign strobe = WriteIO & ~wrQ;
  assign wrData = strobe & hit[0];
  assign wrCtrl = strobe & hit[1];
  assign full   = (countReg == CW'(DEPTH));
  assign empty  = (countReg == '0);
  assign busy   = (stateReg != IDLE);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pushEn = wrData & (~full | popEn);
  assign bitEnd = (baudReg == divA - 16'd1);
  assign unusedBits = ^DataOutput[31:17];

  always_ff @(posedge CLK) begin
    if (pushEn) mem[wrPtr] <= DataOutput[7:0];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wrQ      <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      countReg <= '0;
      ovf      <= 1'b0;
      lastByte <= 8'd0;
      divP     <= DIV_RESET;
      divA     <= DIV_RESET;
      shreg    <= 8'd0;
      stateReg <= IDLE;
      baudReg  <= 16'd0;
      bitReg   <= 3'd0;
    end else begin
      wrQ <= WriteIO;
      if (pushEn) begin
        wrPtr    <= wrPtr + FIFO_AW'(1);
        lastByte <= DataOutput[7:0];
      end
      if (popEn) rdPtr <= rdPtr + FIFO_AW'(1);
      countReg <= countReg + CW'(pushEn) - CW'(popEn);
      if (wrData & ~pushEn) ovf <= 1'b1;
      else if (wrCtrl & DataOutput[16]) ovf <= 1'b0;
      if (wrCtrl) divP <= (DataOutput[15:0] < 16'd2) ? 16'd2 : DataOutput[15:0];
      // divA is latched only at frame start so mid-frame divisor writes wait a frame.
      if (popEn) begin
        shreg <= mem[rdPtr];
        divA  <= divP;
      end else if (shiftEn) begin
        shreg <= {1'b0, shreg[7:1]};
      end
      stateReg <= stateNext;
      baudReg  <= baudNext;
      bitReg   <= bitNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    baudNext  = baudReg + 16'd1;
    bitNext   = bitReg;
    popEn     = 1'b0;
    shiftEn   = 1'b0;
    case (stateReg)
      IDLE: begin
        baudNext = 16'd0;
        if (!empty) begin
          popEn     = 1'b1;
          bitNext   = 3'd0;
          stateNext = START;
        end
      end
      START: begin
        if (bitEnd) begin
          baudNext  = 16'd0;
          bitNext   = 3'd0;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (bitEnd) begin
          baudNext = 16'd0;
          shiftEn  = 1'b1;
          if (bitReg == 3'd7) stateNext = STOP;
          else bitNext = bitReg + 3'd1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          baudNext = 16'd0;
          // Chain straight into the next frame when data is waiting.
          if (!empty) begin
            popEn     = 1'b1;
            bitNext   = 3'd0;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    TX = 1'b1;
    case (stateReg)
      START:   TX = 1'b0;
      DATA:    TX = shreg[0];
      default: TX = 1'b1;
    endcase
  end

  assign statusWord = {15'b0, ovf, busy, full, empty, 13'(countReg)};
  assign RdHit      = |hit;

  always_comb begin
    RdData = 32'd0;
    if (hit[0])      RdData = {24'b0, lastByte};
    else if (hit[1]) RdData = statusWord;
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io: stimulus queues expected frames, a serial
// monitor decodes TX cycle by cycle and compares against the queue.
module tb_uart_tx_io;

  logic        CLK;
  logic        Reset;
  logic [8:0]  AddressIO;
  logic [31:0] DataOutput;
  logic        WriteIO;
  logic [31:0] RdData;
  logic        RdHit;
  logic        TX;

  uart_tx_io dut (
    .CLK(CLK), .Reset(Reset), .AddressIO(AddressIO), .DataOutput(DataOutput),
    .WriteIO(WriteIO), .RdData(RdData), .RdHit(RdHit), .TX(TX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] b;
    int         div;
  } expT;

  expT  expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   monEn = 1'b1;
  bit   monActive = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end else begin
      $display("check %s: %08h ok", name, act);
    end
  endtask

  task automatic pushExp(input logic [7:0] b, input int div);
    expT e;
    e.b = b;
    e.div = div;
    expQ.push_back(e);
  endtask

  task automatic cpuWrite(input logic [8:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    AddressIO  = a;
    DataOutput = d;
    WriteIO    = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    WriteIO = 1'b0;
  endtask

  task automatic readChk(input string name, input logic [8:0] a, input logic [31:0] req);
    @(posedge CLK);
    #1;
    AddressIO = a;
    @(negedge CLK);
    chk(name, RdData, req);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || monActive) && n < maxCycles) begin
      @(posedge CLK);
      n++;
    end
    vectors++;
    if (n >= maxCycles) begin
      miscompares++;
      $display("FAIL %s: drain timeout, %0d frames outstanding, required 0", name, expQ.size());
    end else begin
      $display("check %s: drained in %0d cycles", name, n);
    end
  endtask

  // Serial monitor: every TX sample of a frame must match the queued byte/divisor.
  initial begin
    expT         cur;
    int          pos;
    int          slot;
    logic        expBit;
    bit          bad;
    logic [7:0]  got;
    cur.b = 8'h00;
    cur.div = 1;
    pos = 0;
    bad = 1'b0;
    got = 8'h00;
    forever begin
      @(negedge CLK);
      if (Reset || !monEn) begin
        monActive = 1'b0;
      end else begin
        if (!monActive && TX == 1'b0) begin
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame: unexpected start bit at %0t, required none", $time);
          end else begin
            cur = expQ.pop_front();
            monActive = 1'b1;
            pos = 0;
            bad = 1'b0;
            got = 8'h00;
          end
        end
        if (monActive) begin
          slot = pos / cur.div;
          if (slot == 0) expBit = 1'b0;
          else if (slot <= 8) expBit = cur.b[slot-1];
          else expBit = 1'b1;
          if (TX !== expBit) bad = 1'b1;
          if (slot >= 1 && slot <= 8 && (pos % cur.div) == 0) got[slot-1] = TX;
          pos++;
          if (pos == 10 * cur.div) begin
            monActive = 1'b0;
            vectors++;
            if (bad) begin
              miscompares++;
              $display("FAIL frame: got byte %02h with bad bit timing/level, required byte %02h at %0d clk/bit",
                       got, cur.b, cur.div);
            end else begin
              $display("frame byte %02h at %0d clk/bit ok", got, cur.div);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowCycles;
    Reset      = 1'b1;
    WriteIO    = 1'b0;
    AddressIO  = 9'd0;
    DataOutput = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("reset_tx", {31'd0, TX}, 32'd1);
    readChk("reset_status", 9'd43, 32'h0000_2000);
    chk("rdhit_43", {31'd0, RdHit}, 32'd1);
    readChk("reset_data", 9'd42, 32'h0000_0000);
    chk("rdhit_42", {31'd0, RdHit}, 32'd1);
    readChk("other_addr_data", 9'd100, 32'h0000_0000);
    chk("rdhit_other", {31'd0, RdHit}, 32'd0);

    // T1: A5 at 4 clk/bit
    cpuWrite(9'd43, 32'd4);
    pushExp(8'hA5, 4);
    cpuWrite(9'd42, 32'h0000_00A5);
    readChk("t1_last_byte", 9'd42, 32'h0000_00A5);
    waitDrain("t1_drain", 200);

    // T2: strobe held 100 cycles, address moved while held
    pushExp(8'h55, 4);
    @(posedge CLK);
    #1;
    AddressIO  = 9'd42;
    DataOutput = 32'h0000_0055;
    WriteIO    = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    AddressIO = 9'd43;
    @(negedge CLK);
    chk("t2_status_held", RdData, 32'h0000_A000);
    repeat (90) @(posedge CLK);
    #1;
    WriteIO = 1'b0;
    waitDrain("t2_drain", 200);

    // T3: overflow with a slow frame in flight
    cpuWrite(9'd43, 32'd50);
    pushExp(8'h00, 50);
    cpuWrite(9'd42, 32'h0000_0000);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) pushExp(8'(i), 50);
      cpuWrite(9'd42, 32'(i));
    end
    readChk("t3_status_full_ovf", 9'd43, 32'h0001_C008);
    readChk("t3_last_pushed", 9'd42, 32'h0000_0008);
    waitDrain("t3_drain", 6000);
    readChk("t3_ovf_sticky", 9'd43, 32'h0001_2000);
    cpuWrite(9'd43, 32'h0001_0004);
    readChk("t3_ovf_cleared", 9'd43, 32'h0000_2000);

    // T4: divisor change mid-frame applies to the next frame only
    pushExp(8'h3C, 4);
    cpuWrite(9'd42, 32'h0000_003C);
    repeat (10) @(posedge CLK);
    pushExp(8'hC3, 8);
    cpuWrite(9'd43, 32'd8);
    cpuWrite(9'd42, 32'h0000_00C3);
    waitDrain("t4_drain", 300);

    // T5: divisor 0 clamps to 2
    pushExp(8'h96, 2);
    cpuWrite(9'd43, 32'd0);
    cpuWrite(9'd42, 32'h0000_0096);
    waitDrain("t5_drain", 100);

    // T6: reset during DATA bit 3 with two bytes queued
    cpuWrite(9'd43, 32'd8);
    monEn = 1'b0;
    cpuWrite(9'd42, 32'h0000_0011);
    cpuWrite(9'd42, 32'h0000_0022);
    cpuWrite(9'd42, 32'h0000_0033);
    readChk("t6_queued", 9'd43, 32'h0000_8002);
    repeat (26) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t6_tx_after_reset", {31'd0, TX}, 32'd1);
    chk("t6_status_after_reset", RdData, 32'h0000_2000);
    Reset = 1'b0;
    monEn = 1'b1;
    lowCycles = 0;
    repeat (300) begin
      @(negedge CLK);
      if (TX !== 1'b1) lowCycles++;
    end
    chk("t6_no_frames", 32'(lowCycles), 32'd0);
    chk("t6_scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
